// File: rtl/sat_pkg.sv
// Shared DPLL definitions: trail entry layout, trace-table encodings and
// the backtrack controller state type.
package sat_pkg;

  localparam int VAR_IDX_MSB = 8;

  localparam logic TYPE_DECIDED = 1'b0;
  localparam logic TYPE_FORCED  = 1'b1;
  localparam logic RW_POP       = 1'b0;
  localparam logic RW_PUSH      = 1'b1;

  typedef struct packed {
    logic                 entry_type;
    logic                 val;
    logic [VAR_IDX_MSB:0] variable;
  } trail_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POP_REQ  = 3'd1,
    ST_POP_WAIT = 3'd2,
    ST_EVAL     = 3'd3,
    ST_PUSH     = 3'd4,
    ST_FINISH   = 3'd5
  } bt_state_t;

endpackage

// File: rtl/backtrack_engine.sv
// Conflict backtracker: unwinds the trace stack to the latest decision,
// clears each popped variable and re-pushes the flipped decision as forced.
module backtrack_engine
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE     = 128,
  parameter int VARIABLE_INDEXES = VAR_IDX_MSB
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                unsat,
  output logic [VARIABLE_INDEXES:0]           flip_var,
  output logic                                flip_val,
  output logic [$clog2(NUM_VARIABLE+1)-1:0]   pop_count,
  output logic                                tt_en,
  output logic                                tt_rw,
  output logic                                tt_type_in,
  output logic                                tt_val_in,
  output logic [VARIABLE_INDEXES:0]           tt_variable,
  input  logic                                tt_type_out,
  input  logic                                tt_val_out,
  input  logic [VARIABLE_INDEXES:0]           tt_variable_out,
  input  logic                                tt_empty,
  output logic                                asg_clr,
  output logic                                asg_set,
  output logic [VARIABLE_INDEXES:0]           asg_idx,
  output logic                                asg_val
);

  localparam int IW   = VARIABLE_INDEXES + 1;
  localparam int PC_W = $clog2(NUM_VARIABLE + 1);

  bt_state_t    state_r;
  trail_entry_t cap_r;

  // Controller FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cap_r       <= '{entry_type: 1'b0, val: 1'b0, variable: {IW{1'b0}}};
      busy        <= 1'b0;
      done        <= 1'b0;
      unsat       <= 1'b0;
      flip_var    <= {IW{1'b0}};
      flip_val    <= 1'b0;
      pop_count   <= {PC_W{1'b0}};
      tt_en       <= 1'b0;
      tt_rw       <= RW_POP;
      tt_type_in  <= TYPE_DECIDED;
      tt_val_in   <= 1'b0;
      tt_variable <= {IW{1'b0}};
      asg_clr     <= 1'b0;
      asg_set     <= 1'b0;
      asg_idx     <= {IW{1'b0}};
      asg_val     <= 1'b0;
    end else begin
      tt_en   <= 1'b0;
      asg_clr <= 1'b0;
      asg_set <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            pop_count <= {PC_W{1'b0}};
            if (tt_empty) begin
              state_r <= ST_FINISH;
              unsat   <= 1'b1;
            end else begin
              state_r <= ST_POP_REQ;
              unsat   <= 1'b0;
              tt_en   <= 1'b1;
              tt_rw   <= RW_POP;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_POP_REQ: begin
          state_r <= ST_POP_WAIT;
        end
        ST_POP_WAIT: begin
          cap_r   <= '{entry_type: tt_type_out, val: tt_val_out, variable: tt_variable_out};
          state_r <= ST_EVAL;
          asg_clr <= 1'b1;
          asg_idx <= tt_variable_out;
          if (pop_count != {PC_W{1'b1}}) begin
            pop_count <= pop_count + {{(PC_W-1){1'b0}}, 1'b1};
          end else begin
            pop_count <= pop_count;
          end
        end
        ST_EVAL: begin
          if (cap_r.entry_type == TYPE_FORCED) begin
            if (tt_empty) begin
              state_r <= ST_FINISH;
              unsat   <= 1'b1;
              done    <= 1'b1;
            end else begin
              state_r <= ST_POP_REQ;
              tt_en   <= 1'b1;
              tt_rw   <= RW_POP;
            end
          end else begin
            state_r     <= ST_PUSH;
            tt_en       <= 1'b1;
            tt_rw       <= RW_PUSH;
            tt_type_in  <= TYPE_FORCED;
            tt_val_in   <= ~cap_r.val;
            tt_variable <= cap_r.variable;
            asg_set     <= 1'b1;
            asg_idx     <= cap_r.variable;
            asg_val     <= ~cap_r.val;
            flip_var    <= cap_r.variable;
            flip_val    <= ~cap_r.val;
          end
        end
        ST_PUSH: begin
          state_r <= ST_FINISH;
          unsat   <= 1'b0;
          done    <= 1'b1;
        end
        ST_FINISH: begin
          // The empty-stack path enters here without done, so it spends one extra cycle.
          if (done) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
